// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the multicycle RV32 controller.
//               The branch decode depends on MULTICYCLE_BRANCH_FULL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT     = 2'b00;
    localparam logic [1:0] RES_MEM_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_S    = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;
    localparam logic [1:0] IMM_J    = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [1:0] immediate_control;
        logic       retire;
        logic       illegal_instr;
    } ctrl_t;

    // All-zero is exactly the quiet encoding: enables off, selects 00, ALU ADD.
    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_ITYPE: return IMM_I;
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            default:           return IMM_NONE;
        endcase
    endfunction

    function automatic logic branch_supported(input logic [2:0] funct3);
`ifdef MULTICYCLE_BRANCH_FULL_EN
        return (funct3 != 3'b010) && (funct3 != 3'b011);
`else
        return funct3 == 3'b000;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module      : multicycle_controller_if
// Description : Controller <-> datapath bundle: IR/flags/memory handshake in,
//               enables and mux selects out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;

    logic [31:0] instruction;
    logic        equal;
    logic        less_than;
    logic        less_than_unsigned;
    logic        mem_ready;

    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        adr_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [1:0]  immediate_control;
    logic        retire;
    logic        illegal_instr;

    modport master (
        input  instruction, equal, less_than, less_than_unsigned, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_control,
               immediate_control, retire, illegal_instr
    );

    modport slave (
        output instruction, equal, less_than, less_than_unsigned, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_control,
               immediate_control, retire, illegal_instr
    );

endinterface

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Maps funct3/funct7[5] onto an ALU operation code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import riscv_pkg::*;
(
    input  wire logic [2:0] i_funct3,
    input  wire logic       i_funct7_b5,
    input  wire logic       i_is_rtype,
    output logic      [3:0] o_alu_control
);

    // Immediate forms carry immediate bits in funct7, so bit 5 only selects
    // SUB for register ops; it still selects SRA for both forms.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_funct3)
            3'b000:  o_alu_control = (i_is_rtype && i_funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_control = ALU_SLL;
            3'b010:  o_alu_control = ALU_SLT;
            3'b011:  o_alu_control = ALU_SLTU;
            3'b100:  o_alu_control = ALU_XOR;
            3'b101:  o_alu_control = i_funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_control = ALU_OR;
            3'b111:  o_alu_control = ALU_AND;
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Moore control FSM for a multicycle RV32 subset datapath.
//               MULTICYCLE_BRANCH_FULL_EN enables all six branch conditions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import riscv_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    multicycle_controller_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      w_ctrl;
    ctrl_t      w_ctrl_out;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_b5;
    logic [3:0] w_dec_alu;
    logic       w_taken;

    assign w_opcode    = bus.instruction[6:0];
    assign w_funct3    = bus.instruction[14:12];
    assign w_funct7_b5 = bus.instruction[30];

    alu_decoder u_alu_decoder (
        .i_funct3      (w_funct3),
        .i_funct7_b5   (w_funct7_b5),
        .i_is_rtype    (state_q == S_EXECR),
        .o_alu_control (w_dec_alu)
    );

`ifdef MULTICYCLE_BRANCH_FULL_EN
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = bus.equal;
            3'b001:  w_taken = !bus.equal;
            3'b100:  w_taken = bus.less_than;
            3'b101:  w_taken = !bus.less_than;
            3'b110:  w_taken = bus.less_than_unsigned;
            3'b111:  w_taken = !bus.less_than_unsigned;
            default: w_taken = 1'b0;
        endcase
    end
`else
    // Only beq can reach BRANCH; everything else traps in DECODE.
    assign w_taken = bus.equal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_ctrl  = CTRL_IDLE;
        w_ctrl.immediate_control =
            (state_q == S_FETCH || state_q == S_TRAP) ? IMM_NONE : imm_sel(w_opcode);

        case (state_q)
            S_FETCH: begin
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.adr_src     = ADR_PC;
                w_ctrl.alu_src_a   = SRC_A_PC;
                w_ctrl.alu_src_b   = SRC_B_FOUR;
                w_ctrl.alu_control = ALU_ADD;
                w_ctrl.result_src  = RES_ALU_RESULT;
                if (bus.mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is formed here and parked in ALUOut.
                w_ctrl.alu_src_a   = SRC_A_OLD_PC;
                w_ctrl.alu_src_b   = SRC_B_IMM;
                w_ctrl.alu_control = ALU_ADD;
                case (w_opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = branch_supported(w_funct3) ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a   = SRC_A_RS1;
                w_ctrl.alu_src_b   = SRC_B_IMM;
                w_ctrl.alu_control = ALU_ADD;
                state_d            = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.adr_src  = ADR_ALUOUT;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_ctrl.result_src = RES_MEM_DATA;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.retire     = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEMWRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.adr_src   = ADR_ALUOUT;
                if (bus.mem_ready) begin
                    w_ctrl.retire = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXECR: begin
                w_ctrl.alu_src_a   = SRC_A_RS1;
                w_ctrl.alu_src_b   = SRC_B_RS2;
                w_ctrl.alu_control = w_dec_alu;
                state_d            = S_ALUWB;
            end
            S_EXECI: begin
                w_ctrl.alu_src_a   = SRC_A_RS1;
                w_ctrl.alu_src_b   = SRC_B_IMM;
                w_ctrl.alu_control = w_dec_alu;
                state_d            = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.retire     = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a   = SRC_A_RS1;
                w_ctrl.alu_src_b   = SRC_B_RS2;
                w_ctrl.alu_control = ALU_SUB;
                w_ctrl.result_src  = RES_ALUOUT;
                w_ctrl.pc_write    = w_taken;
                w_ctrl.retire      = 1'b1;
                state_d            = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE target while old PC + 4 goes to ALUOut for rd.
                w_ctrl.alu_src_a   = SRC_A_OLD_PC;
                w_ctrl.alu_src_b   = SRC_B_FOUR;
                w_ctrl.alu_control = ALU_ADD;
                w_ctrl.result_src  = RES_ALUOUT;
                w_ctrl.pc_write    = 1'b1;
                state_d            = S_ALUWB;
            end
            S_TRAP: begin
                w_ctrl.illegal_instr = 1'b1;
                state_d              = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset quiets the outputs in the same cycle so an in-flight access is dropped.
    assign w_ctrl_out = reset ? CTRL_IDLE : w_ctrl;

    assign bus.pc_write          = w_ctrl_out.pc_write;
    assign bus.ir_write          = w_ctrl_out.ir_write;
    assign bus.mem_read          = w_ctrl_out.mem_read;
    assign bus.mem_write         = w_ctrl_out.mem_write;
    assign bus.reg_write         = w_ctrl_out.reg_write;
    assign bus.adr_src           = w_ctrl_out.adr_src;
    assign bus.alu_src_a         = w_ctrl_out.alu_src_a;
    assign bus.alu_src_b         = w_ctrl_out.alu_src_b;
    assign bus.result_src        = w_ctrl_out.result_src;
    assign bus.alu_control       = w_ctrl_out.alu_control;
    assign bus.immediate_control = w_ctrl_out.immediate_control;
    assign bus.retire            = w_ctrl_out.retire;
    assign bus.illegal_instr     = w_ctrl_out.illegal_instr;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller; expected output
//               words are queued as each cycle is driven, then compared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    typedef struct {
        logic        ready;
        logic        eq;
        logic        rst;
        logic [19:0] exp;
    } step_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [19:0] exp_q[$];
    logic [19:0] w_outs;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign w_outs = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                     bus.reg_write, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
                     bus.result_src, bus.alu_control, bus.immediate_control,
                     bus.retire, bus.illegal_instr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic pcw, irw, mr, mw, rw, adr,
                                       input logic [1:0] a, b, res,
                                       input logic [3:0] alu,
                                       input logic [1:0] imm,
                                       input logic ret, ill);
        return {pcw, irw, mr, mw, rw, adr, a, b, res, alu, imm, ret, ill};
    endfunction

    function automatic logic [19:0] e_fetch(input logic r);
        return mk(r, r, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 4'b0000, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] e_decode(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'b0000, imm, 0, 0);
    endfunction
    function automatic logic [19:0] e_exec(input logic [1:0] b, input logic [3:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 2'b10, b, 2'b00, alu, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] e_aluwb(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, imm, 1, 0);
    endfunction
    function automatic logic [19:0] e_memadr(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0000, imm, 0, 0);
    endfunction
    function automatic logic [19:0] e_memread();
        return mk(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] e_memwb();
        return mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00, 1, 0);
    endfunction
    function automatic logic [19:0] e_memwrite(input logic r);
        return mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, r, 0);
    endfunction
    function automatic logic [19:0] e_branch(input logic t);
        return mk(t, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0001, 2'b10, 1, 0);
    endfunction
    function automatic logic [19:0] e_jal();
        return mk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 4'b0000, 2'b11, 0, 0);
    endfunction
    function automatic logic [19:0] e_trap();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 1);
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue its expectation.
    task automatic apply(input logic [31:0] ins, input step_t st);
        @(negedge clk);
        bus.instruction        = ins;
        bus.mem_ready          = st.ready;
        bus.equal              = st.eq;
        bus.less_than          = 1'b0;
        bus.less_than_unsigned = 1'b0;
        reset                  = st.rst;
        exp_q.push_back(st.exp);
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b1, 20'h0});
        s.push_back('{1'b1, 1'b1, 1'b1, 20'h0});
        s.push_back('{1'b0, 1'b0, 1'b0, e_fetch(1'b0)});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0000_0013, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL reset cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    task automatic test_add();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b00)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_exec(2'b00, 4'b0000)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_aluwb(2'b00)});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0020_81B3, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL add cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    // Several R/I ALU ops issued back to back, covering decoder corner cases.
    task automatic test_back_to_back_alu();
        logic [31:0] ins [5] = '{32'h4020_81B3, 32'h0020_F1B3, 32'h4020_D193,
                                 32'h4000_8193, 32'h0050_B193};
        logic [3:0]  alu [5] = '{4'b0001, 4'b0010, 4'b1001, 4'b0000, 4'b0110};
        logic [1:0]  srcb[5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        logic [19:0] want;
        for (int k = 0; k < 5; k++) begin
            step_t s[$];
            s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
            s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b00)});
            s.push_back('{1'b1, 1'b0, 1'b0, e_exec(srcb[k], alu[k])});
            s.push_back('{1'b1, 1'b0, 1'b0, e_aluwb(2'b00)});
            for (int i = 0; i < s.size(); i++) begin
                apply(ins[k], s[i]);
                #1;
                want = exp_q.pop_front();
                checks++;
                if (w_outs !== want) begin
                    failures++;
                    $display("FAIL alu%0d cyc%0d got=%05h want=%05h", k, i, w_outs, want);
                end
            end
        end
    endtask

    task automatic test_load();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b00)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_memadr(2'b00)});
        s.push_back('{1'b0, 1'b0, 1'b0, e_memread()});
        s.push_back('{1'b0, 1'b0, 1'b0, e_memread()});
        s.push_back('{1'b1, 1'b0, 1'b0, e_memread()});
        s.push_back('{1'b1, 1'b0, 1'b0, e_memwb()});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0080_2283, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL load cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    task automatic test_branch();
        logic [19:0] want;
        for (int k = 0; k < 2; k++) begin
            step_t s[$];
            logic  eq;
            eq = (k == 0);
            s.push_back('{1'b1, eq, 1'b0, e_fetch(1'b1)});
            s.push_back('{1'b1, eq, 1'b0, e_decode(2'b10)});
            s.push_back('{1'b1, eq, 1'b0, e_branch(eq)});
            for (int i = 0; i < s.size(); i++) begin
                apply(32'h0020_8463, s[i]);
                #1;
                want = exp_q.pop_front();
                checks++;
                if (w_outs !== want) begin
                    failures++;
                    $display("FAIL beq eq=%0d cyc%0d got=%05h want=%05h", eq, i, w_outs, want);
                end
            end
        end
    endtask

    task automatic test_jal();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b0, 1'b0, 1'b0, e_fetch(1'b0)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b11)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_jal()});
        s.push_back('{1'b1, 1'b0, 1'b0, e_aluwb(2'b11)});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0080_00EF, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL jal cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    task automatic test_store_reset();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b01)});
        s.push_back('{1'b0, 1'b0, 1'b0, e_memadr(2'b01)});
        s.push_back('{1'b0, 1'b0, 1'b0, e_memwrite(1'b0)});
        s.push_back('{1'b0, 1'b0, 1'b1, 20'h0});
        s.push_back('{1'b0, 1'b0, 1'b0, e_fetch(1'b0)});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0011_2423, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL sw_reset cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    task automatic test_store();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b01)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_memadr(2'b01)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_memwrite(1'b1)});
        s.push_back('{1'b0, 1'b0, 1'b0, e_fetch(1'b0)});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0011_2423, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL sw cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    task automatic test_bne();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b10)});
`ifdef MULTICYCLE_BRANCH_FULL_EN
        s.push_back('{1'b1, 1'b0, 1'b0, e_branch(1'b1)});
        s.push_back('{1'b0, 1'b0, 1'b0, e_fetch(1'b0)});
`else
        for (int j = 0; j < 10; j++) begin
            s.push_back('{j[0], j[1], 1'b0, e_trap()});
        end
        s.push_back('{1'b1, 1'b0, 1'b1, 20'h0});
        s.push_back('{1'b0, 1'b0, 1'b0, e_fetch(1'b0)});
`endif
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0020_9463, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL bne cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        logic [19:0] want;
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        s.push_back('{1'b1, 1'b0, 1'b0, e_decode(2'b00)});
        for (int j = 0; j < 6; j++) begin
            s.push_back('{j[0], ~j[0], 1'b0, e_trap()});
        end
        s.push_back('{1'b1, 1'b1, 1'b1, 20'h0});
        s.push_back('{1'b1, 1'b0, 1'b0, e_fetch(1'b1)});
        for (int i = 0; i < s.size(); i++) begin
            apply(32'h0000_007F, s[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (w_outs !== want) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%05h want=%05h", i, w_outs, want);
            end
        end
    endtask

    initial begin
        checks                 = 0;
        failures               = 0;
        reset                  = 1'b1;
        bus.instruction        = 32'h0;
        bus.equal              = 1'b0;
        bus.less_than          = 1'b0;
        bus.less_than_unsigned = 1'b0;
        bus.mem_ready          = 1'b0;

        test_reset();
        test_add();
        test_back_to_back_alu();
        test_load();
        test_branch();
        test_jal();
        test_store();
        test_store_reset();
        test_bne();
        test_illegal();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 Inputs SHALL be: instruction  in  32  IR contents; equal, less_than, less_than_unsigned  in  1 each  ALU compare flags (rs1 vs rs2); mem_ready  in  1  memory access completes this cycle.
REQ-003 Outputs SHALL be: pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  enables; adr_src  out  1  0=PC, 1=ALUOut.
REQ-004 Outputs SHALL be: alu_src_a  out  2  00=PC, 01=old PC, 10=rs1; alu_src_b  out  2  00=rs2, 01=imm, 10=const 4.
REQ-005 Outputs SHALL be: result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result; alu_control  out  4  ALU op; immediate_control  out  2  00=I, 01=S, 10=B, 11=J.
REQ-006 Outputs SHALL be: retire  out  1  one-cycle pulse on last cycle of each instruction; illegal_instr  out  1  sticky trap flag.

Function
REQ-007 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP; outputs are Moore functions of state plus instruction/flags/mem_ready.
REQ-008 FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10; ir_write=pc_write=1 and advance to DECODE only when mem_ready=1, else hold.
REQ-009 DECODE: alu_src_a=01, alu_src_b=01, ADD (branch/jump target into ALUOut); next by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, other -> TRAP.
REQ-010 MEMADR: alu_src_a=10, alu_src_b=01, ADD; next MEMREAD (load) or MEMWRITE (store).
REQ-011 MEMREAD: mem_read=1, adr_src=1; hold until mem_ready, then MEMWB. MEMWB: result_src=01, reg_write=1, retire=1, next FETCH.
REQ-012 MEMWRITE: mem_write=1, adr_src=1; hold until mem_ready; on mem_ready retire=1, next FETCH.
REQ-013 EXECR: alu_src_a=10, alu_src_b=00, alu_control from funct3/funct7[5]; EXECI: alu_src_b=01, funct7[5] honoured only for funct3=101; both next ALUWB.
REQ-014 ALUWB: result_src=00, reg_write=1, retire=1, next FETCH.
REQ-015 BRANCH: alu_src_a=10, alu_src_b=00, SUB, result_src=00; pc_write=taken; retire=1; next FETCH.
REQ-016 JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1; next ALUWB (rd=old PC+4).
REQ-017 immediate_control SHALL be I for loads/I-ALU, S for stores, B for branches, J for JAL, 00 elsewhere.
REQ-018 TRAP: illegal_instr=1, all enables 0, no exit except reset.
REQ-019 Latency with mem_ready=1: branch 3 cycles, R/I-ALU/store/JAL 4, load 5; each mem_ready=0 cycle adds one.
REQ-020 Unused mux selects SHALL be 00 and alu_control ADD in states not listing them.

Reset
REQ-021 While reset=1 all enables, retire, illegal_instr SHALL be 0 and selects 00, even mid-access (e.g. mem_write drops in the reset cycle); next state FETCH.

Configuration
REQ-022 Macro MULTICYCLE_BRANCH_FULL_EN defined: taken = beq equal, bne !equal, blt less_than, bge !less_than, bltu less_than_unsigned, bgeu !less_than_unsigned; funct3 010/011 -> TRAP.
REQ-023 Macro undefined: only beq (funct3 000) supported; any other branch funct3 -> TRAP from DECODE.

Structure
REQ-024 State enum, alu_control codes (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001), opcode and mux-select constants SHALL live in shared package riscv_pkg.
REQ-025 funct3/funct7 to alu_control mapping SHALL be the existing alu_decoder sub-module, instantiated once.

Verification
REQ-026 0x002081B3 (add x3,x1,x2), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write and retire in cycle 4 only, alu_control=0000 in EXECR.
REQ-027 0x00802283 (lw x5,8(x0)), mem_ready low 2 cycles in MEMREAD -> 7 cycles, adr_src=1 in MEMREAD, result_src=01 with reg_write in MEMWB.
REQ-028 0x00208463 (beq) equal=1 -> pc_write=1 in cycle 3; equal=0 -> pc_write=0, retire=1 in cycle 3.
REQ-029 0x00209463 (bne), macro undefined -> TRAP, illegal_instr=1 held 10 cycles; macro defined, equal=0 -> pc_write=1 cycle 3.
REQ-030 sw 0x00112423 with mem_ready=0, reset pulsed in MEMWRITE -> mem_write=0 that cycle, FETCH next, illegal_instr=0.
REQ-031 opcode 0x7F -> illegal_instr=1 from cycle 3, no enable ever asserted until reset.
